// File: rtl/ps2_key_assembler_if.sv
// PS/2 key assembler bundle: raw keyboard lines in, assembled key events out.
// Modport master is the side that drives the raw lines and consumes events;
// modport slave is the assembler itself.
interface ps2_key_assembler_if;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [65:0] ps2_key;
   logic        err;
   logic [7:0]  err_cnt;

   modport master (
      output ps2_clk_in, ps2_data_in,
      input  ps2_key, err, err_cnt
   );

   modport slave (
      input  ps2_clk_in, ps2_data_in,
      output ps2_key, err, err_cnt
   );
endinterface

// File: rtl/ps2_key_assembler.sv
// PS/2 key assembler: conditions the raw PS/2 lines, deserialises device
// frames and folds multi-byte scancode sequences (E0/F0 prefixes, E1 Pause,
// PrtScr) into one 66-bit event word whose bit 64 toggles per event.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses repeated make
// events of a key that is already held down.
module ps2_key_assembler #(
   parameter int FILT_CYCLES = 8,
   parameter int BIT_TIMEOUT = 11200,
   parameter int SEQ_TIMEOUT = 112000
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   ps2_key_assembler_if.slave bus
);

   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int BW = $clog2(BIT_TIMEOUT + 1);
   localparam int SW = $clog2(SEQ_TIMEOUT + 1);

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_E1 = 8'hE1;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic {ASM_NORMAL, ASM_PAUSE} asm_state_t;

   // ---------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------
   logic          clk_meta, clk_sync, data_meta, data_sync;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          filt_fall;

   // Two-flop synchronisers; they reset to the idle-high line level.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         // NOTE: non-blocking so each flop takes the pre-edge value of the one
         // before it; blocking would collapse the chain into a single flop.
         clk_meta  <= bus.ps2_clk_in;
         clk_sync  <= clk_meta;
         data_meta <= bus.ps2_data_in;
         data_sync <= data_meta;
      end
   end

   // A falling edge is the cycle the filter accepts a new low level.
   assign filt_fall = clk_filt && !clk_sync && (filt_cnt == FW'(FILT_CYCLES - 1));

   // Glitch filter: the accepted clock level follows the synchronised clock
   // only after it has held a new level for FILT_CYCLES consecutive cycles.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_sync == clk_filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
         clk_filt <= clk_sync;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   rx_state_t     rx_state, rx_next;
   logic [7:0]    rx_shift, shift_next;
   logic [2:0]    rx_bit_idx, idx_next;
   logic          rx_par, par_next;
   logic [BW-1:0] bit_timer;
   logic          good_byte, frame_err, bit_to;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          err_q;
   logic [7:0]    err_cnt_q;

   // Receive state register plus bit timer, byte strobe and error tracking.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rx_state   <= RX_IDLE;
         rx_shift   <= '0;
         rx_bit_idx <= '0;
         rx_par     <= 1'b0;
         bit_timer  <= '0;
         rx_valid   <= 1'b0;
         rx_byte    <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         rx_state   <= rx_next;
         rx_shift   <= shift_next;
         rx_bit_idx <= idx_next;
         rx_par     <= par_next;
         if (filt_fall || rx_state == RX_IDLE)
            bit_timer <= '0;
         else
            bit_timer <= bit_timer + 1'b1;
         rx_valid <= good_byte;
         if (good_byte)
            rx_byte <= rx_shift;
         // A frame error and a timeout landing together still give one pulse.
         err_q <= frame_err || bit_to;
         if ((frame_err || bit_to) && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   // Receive next-state: start bit, 8 data bits LSB first, odd parity, stop.
   always_comb begin
      // NOTE: every output gets a default before any branch; a path that left
      // one unassigned would make it hold its value, i.e. infer a latch.
      rx_next    = rx_state;
      shift_next = rx_shift;
      idx_next   = rx_bit_idx;
      par_next   = rx_par;
      good_byte  = 1'b0;
      frame_err  = 1'b0;
      bit_to     = 1'b0;
      if (filt_fall) begin
         unique case (rx_state)
            RX_IDLE: begin
               if (!data_sync) begin
                  rx_next  = RX_DATA;
                  idx_next = '0;
                  par_next = 1'b0;
               end
            end
            RX_DATA: begin
               shift_next = {data_sync, rx_shift[7:1]};
               par_next   = rx_par ^ data_sync;
               idx_next   = rx_bit_idx + 3'd1;
               if (rx_bit_idx == 3'd7)
                  rx_next = RX_PARITY;
            end
            RX_PARITY: begin
               par_next = rx_par ^ data_sync;
               rx_next  = RX_STOP;
            end
            RX_STOP: begin
               rx_next = RX_IDLE;
               if (data_sync && rx_par)
                  good_byte = 1'b1;
               else
                  frame_err = 1'b1;
            end
         endcase
      end else if (rx_state != RX_IDLE && bit_timer == BW'(BIT_TIMEOUT - 1)) begin
         rx_next = RX_IDLE;
         bit_to  = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Sequence assembler
   // ---------------------------------------------------------------------
   // history holds at most 7 bytes between strobes: the 8th byte of any
   // sequence always completes it, so it is only ever seen in hist_new.
   asm_state_t    asm_state, asm_next;
   logic [55:0]   history, hist_next;
   logic [3:0]    byte_cnt, cnt_next;
   logic          pend_valid, pend_v_next;
   logic [63:0]   pend_key, pend_key_next;
   logic          defer_valid, defer_v_next;
   logic [63:0]   defer_key, defer_key_next;
   logic          defer_bypass, defer_bypass_next;
   logic [SW-1:0] seq_timer;
   logic          seq_active, seq_tmo;

   logic [63:0]   hist_new, merged;
   logic [3:0]    cnt_new, cnt_m1;
   logic [7:0]    first_byte;
   logic          seq_done, seq_pause, seq_is_prt;

   logic          emit_req, emit_bypass;
   logic [63:0]   emit_key;

   assign seq_active = (byte_cnt != 4'd0) || pend_valid;
   assign seq_tmo    = seq_active && (seq_timer == SW'(SEQ_TIMEOUT - 1));

   // Assembler registers and the inter-byte sequence timer.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         asm_state    <= ASM_NORMAL;
         history      <= '0;
         byte_cnt     <= '0;
         pend_valid   <= 1'b0;
         pend_key     <= '0;
         defer_valid  <= 1'b0;
         defer_key    <= '0;
         defer_bypass <= 1'b0;
         seq_timer    <= '0;
      end else begin
         asm_state    <= asm_next;
         history      <= hist_next;
         byte_cnt     <= cnt_next;
         pend_valid   <= pend_v_next;
         pend_key     <= pend_key_next;
         defer_valid  <= defer_v_next;
         defer_key    <= defer_key_next;
         defer_bypass <= defer_bypass_next;
         if (rx_valid || err_q || seq_tmo || !seq_active)
            seq_timer <= '0;
         else
            seq_timer <= seq_timer + 1'b1;
      end
   end

   // Assembler next-state and event request. A deferred event always fires
   // the cycle after it is queued, long before the next byte can arrive, so
   // it never competes with another emission.
   always_comb begin
      asm_next          = asm_state;
      hist_next         = history;
      cnt_next          = byte_cnt;
      pend_v_next       = pend_valid;
      pend_key_next     = pend_key;
      defer_v_next      = 1'b0;
      defer_key_next    = defer_key;
      defer_bypass_next = defer_bypass;
      emit_req          = 1'b0;
      emit_key          = '0;
      emit_bypass       = 1'b0;
      seq_done          = 1'b0;
      seq_pause         = 1'b0;

      hist_new   = {history, rx_byte};
      cnt_new    = byte_cnt + 4'd1;
      cnt_m1     = cnt_new - 4'd1;
      first_byte = 8'(hist_new >> {cnt_m1, 3'b000});
      merged     = (pend_key << {cnt_new, 3'b000}) | hist_new;
      seq_is_prt = (asm_state == ASM_NORMAL) &&
                   (((cnt_new == 4'd2) && (hist_new[15:0] == 16'hE012)) ||
                    ((cnt_new == 4'd3) && (hist_new[23:0] == 24'hE0F07C)));

      if (defer_valid) begin
         emit_req    = 1'b1;
         emit_key    = defer_key;
         emit_bypass = defer_bypass;
      end

      if (err_q) begin
         // Frame error or bit timeout: drop everything gathered so far.
         asm_next    = ASM_NORMAL;
         hist_next   = '0;
         cnt_next    = '0;
         pend_v_next = 1'b0;
      end else if (rx_valid) begin
         unique case (asm_state)
            ASM_NORMAL: begin
               if ((rx_byte == CODE_E0 || rx_byte == CODE_F0) && cnt_new != 4'd8) begin
                  hist_next = hist_new[55:0];
                  cnt_next  = cnt_new;
               end else if (rx_byte == CODE_E1) begin
                  // Pause restarts the sequence so its 8 bytes count from E1.
                  asm_next  = ASM_PAUSE;
                  hist_next = {48'h0, CODE_E1};
                  cnt_next  = 4'd1;
               end else begin
                  seq_done = 1'b1;
               end
            end
            ASM_PAUSE: begin
               if (cnt_new == 4'd8) begin
                  seq_done  = 1'b1;
                  seq_pause = 1'b1;
               end else begin
                  hist_next = hist_new[55:0];
                  cnt_next  = cnt_new;
               end
            end
         endcase

         if (seq_done) begin
            asm_next  = ASM_NORMAL;
            hist_next = '0;
            cnt_next  = '0;
            if (pend_valid && first_byte == CODE_E0) begin
               // Second half of PrtScr: one event, held half in the upper bytes.
               emit_req    = 1'b1;
               emit_key    = merged;
               emit_bypass = 1'b1;
               pend_v_next = 1'b0;
            end else if (pend_valid) begin
               emit_req          = 1'b1;
               emit_key          = pend_key;
               emit_bypass       = 1'b1;
               pend_v_next       = 1'b0;
               defer_v_next      = 1'b1;
               defer_key_next    = hist_new;
               defer_bypass_next = seq_pause;
            end else if (seq_is_prt) begin
               pend_v_next   = 1'b1;
               pend_key_next = hist_new;
            end else begin
               emit_req    = 1'b1;
               emit_key    = hist_new;
               emit_bypass = seq_pause;
            end
         end
      end else if (seq_tmo) begin
         // Idle too long: a held PrtScr half goes out alone, a prefix is lost.
         asm_next  = ASM_NORMAL;
         hist_next = '0;
         cnt_next  = '0;
         if (pend_valid) begin
            emit_req    = 1'b1;
            emit_key    = pend_key;
            emit_bypass = 1'b1;
            pend_v_next = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Typematic filter and event output
   // ---------------------------------------------------------------------
   logic        suppress;
   logic [64:0] key_q;

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [511:0] held;
   logic         is_ext, is_brk;
   logic [8:0]   held_idx;

   // Classify the event: E0 anywhere marks extended, F0 anywhere marks break.
   // Pause, merged PrtScr and lone PrtScr halves are framing, not key presses,
   // and arrive flagged as bypass.
   always_comb begin
      is_ext = 1'b0;
      is_brk = 1'b0;
      for (int i = 1; i < 8; i++) begin
         if (emit_key[8*i +: 8] == CODE_E0) is_ext = 1'b1;
         if (emit_key[8*i +: 8] == CODE_F0) is_brk = 1'b1;
      end
      held_idx = {is_ext, emit_key[7:0]};
      suppress = emit_req && !emit_bypass && !is_brk && held[held_idx];
   end

   // Held-key map: make sets the key's bit, break clears it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      // NOTE: the map is reset even though it is a memory-like array; a stale
      // bit after reset would silently swallow that key's first press.
      if (!reset_n)
         held <= '0;
      else if (emit_req && !emit_bypass)
         held[held_idx] <= !is_brk;
   end
`else
   // Without the filter every completed sequence is emitted.
   logic unused_bypass;
   assign unused_bypass = emit_bypass;
   assign suppress      = 1'b0;
`endif

   // Event word: latch the assembled bytes and flip the toggle bit.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_q <= '0;
      end else if (emit_req && !suppress) begin
         key_q[63:0] <= emit_key;
         key_q[64]   <= ~key_q[64];
      end
   end

   assign bus.ps2_key = {1'b0, key_q};
   assign bus.err     = err_q;
   assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_assembler.sv
// Self-checking bench for ps2_key_assembler: table-driven scancode sequences
// plus hand-written timeout, error, glitch, typematic and reset sequences.
module tb_ps2_key_assembler;

   localparam int FILT   = 8;
   localparam int BIT_TO = 200;
   localparam int SEQ_TO = 2000;
   localparam int HALF   = 20;   // PS/2 clock half period in clk_sys cycles
   localparam int GAP    = 60;   // idle cycles between frames

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;

   ps2_key_assembler_if bus ();

   ps2_key_assembler #(
      .FILT_CYCLES(FILT),
      .BIT_TIMEOUT(BIT_TO),
      .SEQ_TIMEOUT(SEQ_TO)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // Event and error-pulse monitor, sampled away from the active edge.
   int   tog_cnt    = 0;
   int   err_pulses = 0;
   logic prev_tog   = 1'b0;
   always @(negedge clk_sys) begin
      prev_tog <= bus.ps2_key[64];
      if (bus.ps2_key[64] != prev_tog) tog_cnt <= tog_cnt + 1;
      if (bus.err) err_pulses <= err_pulses + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_bit(input logic b);
      bus.ps2_data_in = b;
      wait_cycles(HALF);
      bus.ps2_clk_in = 1'b0;
      wait_cycles(HALF);
      bus.ps2_clk_in = 1'b1;
   endtask

   // Sends the first nbits of a frame (start, data LSB first, parity, stop).
   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      bus.ps2_data_in = 1'b1;
      wait_cycles(GAP);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   typedef struct {
      string       name;
      int          n;
      logic [63:0] seq;      // first byte sent is the most significant of n
      logic [63:0] exp_key;
      int          exp_tog;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          t0, e0;
      logic [63:0] s;

      vecs[0] = '{"make 1C",         1, 64'h1C,               64'h1C,               1};
      vecs[1] = '{"break 1C",        2, 64'hF01C,             64'hF01C,             1};
      vecs[2] = '{"ext break 75",    3, 64'hE0F075,           64'hE0F075,           1};
      vecs[3] = '{"pause",           8, 64'hE11477E1F014F077, 64'hE11477E1F014F077, 1};
      vecs[4] = '{"prtscr make",     4, 64'hE012E07C,         64'hE012E07C,         1};
      vecs[5] = '{"prtscr break",    6, 64'hE0F07CE0F012,     64'hE0F07CE0F012,     1};
      vecs[6] = '{"ext make 74",     2, 64'hE074,             64'hE074,             1};
      vecs[7] = '{"pending then 2D", 3, 64'hE0122D,           64'h2D,               2};

      bus.ps2_clk_in  = 1'b1;
      bus.ps2_data_in = 1'b1;
      reset_n         = 1'b0;
      wait_cycles(5);
      check("reset ps2_key", bus.ps2_key, 66'h0);
      check("reset err", 66'(bus.err), 66'h0);
      check("reset err_cnt", 66'(bus.err_cnt), 66'h0);
      reset_n = 1'b1;
      wait_cycles(10);

      // Table-driven sequences
      for (int v = 0; v < 8; v++) begin
         t0 = tog_cnt;
         for (int i = 0; i < vecs[v].n; i++) begin
            s = vecs[v].seq >> (8 * (vecs[v].n - 1 - i));
            send_byte(s[7:0]);
         end
         wait_cycles(20);
         check({vecs[v].name, " key"}, {2'b00, bus.ps2_key[63:0]}, {2'b00, vecs[v].exp_key});
         check({vecs[v].name, " toggles"}, 66'(tog_cnt - t0), 66'(vecs[v].exp_tog));
      end

      // Lone PrtScr half is held, then released by the sequence timeout
      t0 = tog_cnt;
      send_byte(8'hE0);
      send_byte(8'h12);
      wait_cycles(SEQ_TO / 2);
      check("prtscr held before timeout", 66'(tog_cnt - t0), 66'd0);
      wait_cycles(SEQ_TO);
      check("prtscr timeout toggles", 66'(tog_cnt - t0), 66'd1);
      check("prtscr timeout key", {2'b00, bus.ps2_key[63:0]}, 66'hE012);

      // A lone prefix is dropped silently on timeout
      t0 = tog_cnt;
      e0 = err_pulses;
      send_byte(8'hE0);
      wait_cycles(SEQ_TO + 500);
      check("prefix drop no event", 66'(tog_cnt - t0), 66'd0);
      check("prefix drop no err", 66'(err_pulses - e0), 66'd0);
      send_byte(8'h15);
      wait_cycles(20);
      check("after prefix drop key", {2'b00, bus.ps2_key[63:0]}, 66'h15);

      // Bad parity flushes the pending E0 prefix
      t0 = tog_cnt;
      send_byte(8'hE0);
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      wait_cycles(20);
      check("bad parity err pulse", 66'(err_pulses), 66'd1);
      check("bad parity err_cnt", 66'(bus.err_cnt), 66'd1);
      check("bad parity no toggle", 66'(tog_cnt - t0), 66'd0);

      // Clock stops after 4 bits: bit timeout
      send_frame(8'h1C, 1'b0, 1'b0, 4);
      wait_cycles(BIT_TO + 100);
      check("bit timeout err_cnt", 66'(bus.err_cnt), 66'd2);
      check("bit timeout err pulse", 66'(err_pulses), 66'd2);
      send_byte(8'h29);
      wait_cycles(20);
      check("recovery key", {2'b00, bus.ps2_key[63:0]}, 66'h29);
      check("recovery toggles", 66'(tog_cnt - t0), 66'd1);

      // Bad stop bit
      t0 = tog_cnt;
      send_frame(8'h29, 1'b0, 1'b1, 11);
      wait_cycles(20);
      check("bad stop err_cnt", 66'(bus.err_cnt), 66'd3);
      check("bad stop no toggle", 66'(tog_cnt - t0), 66'd0);

      // 3-cycle clock glitch with data low must not look like a start bit
      t0 = tog_cnt;
      bus.ps2_data_in = 1'b0;
      wait_cycles(5);
      bus.ps2_clk_in = 1'b0;
      wait_cycles(3);
      bus.ps2_clk_in = 1'b1;
      wait_cycles(BIT_TO + 100);
      bus.ps2_data_in = 1'b1;
      wait_cycles(GAP);
      check("glitch err_cnt", 66'(bus.err_cnt), 66'd3);
      check("glitch no toggle", 66'(tog_cnt - t0), 66'd0);

      // Typematic repeats
      t0 = tog_cnt;
      repeat (5) send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      wait_cycles(20);
`ifdef PS2_TYPEMATIC_FILTER_EN
      check("typematic toggles", 66'(tog_cnt - t0), 66'd2);
`else
      check("typematic toggles", 66'(tog_cnt - t0), 66'd6);
`endif
      check("typematic final key", {2'b00, bus.ps2_key[63:0]}, 66'hF01C);

      // Reset in the middle of a frame, then a clean frame
      for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
      reset_n = 1'b0;
      wait_cycles(5);
      check("mid-frame reset ps2_key", bus.ps2_key, 66'h0);
      check("mid-frame reset err_cnt", 66'(bus.err_cnt), 66'h0);
      reset_n = 1'b1;
      wait_cycles(GAP);
      t0 = tog_cnt;
      send_byte(8'h1C);
      wait_cycles(20);
      check("post-reset key", bus.ps2_key, {2'b01, 64'h1C});
      check("post-reset toggles", 66'(tog_cnt - t0), 66'd1);
      check("post-reset err_cnt", 66'(bus.err_cnt), 66'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
